// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives the instruction memory address and
// presents captured words to decode over valid/ready. Optional halt detection: FETCH_HALT_DETECT_EN.
module fetch_sequencer #(
  parameter int                  ADDR_W      = 8,
  parameter int                  INSTR_W     = 8,
  parameter logic [ADDR_W-1:0]   RESET_PC    = ADDR_W'(10),
  parameter logic [INSTR_W-1:0]  HALT_OPCODE = INSTR_W'(8'b11100000)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               run,
  output logic [ADDR_W-1:0]  endereco,
  input  logic [INSTR_W-1:0] instrucao,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               busy,
  output logic               halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              load;
  logic              take;

  // The output register may be refilled when it is empty or being drained this edge.
  assign load = !instr_valid || instr_ready;
  assign take = instr_valid && instr_ready;

  assign endereco = pc;
  assign busy     = (state == FETCH);

`ifdef FETCH_HALT_DETECT_EN
  logic halt_hit;
  assign halt_hit = (instrucao == HALT_OPCODE);
  assign halted   = (state == HALT);
`else
  assign halted   = 1'b0;
`endif

  // NOTE: non-blocking assignments throughout, so a later assignment in this block
  // (redirect flush, capture) cleanly overrides the default drain of instr_valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      if (take) instr_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (redirect_valid) pc <= redirect_addr;
          else if (run)       state <= FETCH;
        end

        FETCH: begin
          if (!redirect_valid) begin
            if (!run) begin
              state <= IDLE;
            end else if (load) begin
              instr_out   <= instrucao;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
`ifdef FETCH_HALT_DETECT_EN
              // A halt word is delivered normally but freezes the PC on its own address.
              if (halt_hit) state <= HALT;
              else          pc    <= pc + ADDR_W'(1);
`else
              pc <= pc + ADDR_W'(1);
`endif
            end
          end
        end

`ifdef FETCH_HALT_DETECT_EN
        HALT: begin
          if (redirect_valid) state <= run ? FETCH : IDLE;
        end
`endif

        default: state <= IDLE;
      endcase

      // Redirect wins over everything: the word read this cycle and any held word are dropped.
      if (redirect_valid) begin
        pc          <= redirect_addr;
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: falling-edge memory model plus a transfer scoreboard.
module tb_fetch_sequencer;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] word;
  } xfer_t;

  logic       clock          = 1'b0;
  logic       reset_n        = 1'b1;
  logic       run            = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_addr  = 8'd0;
  logic       instr_ready    = 1'b0;
  logic [7:0] instrucao      = 8'd0;
  logic [7:0] endereco;
  logic [7:0] instr_out;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       busy;
  logic       halted;

  logic [7:0] mem [256];
  xfer_t      sb [$];
  xfer_t      e;
  int         tests = 0;
  int         fails = 0;

  fetch_sequencer #(
    .ADDR_W(8), .INSTR_W(8), .RESET_PC(8'd10), .HALT_OPCODE(8'hE0)
  ) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .endereco(endereco),
    .instrucao(instrucao), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .busy(busy), .halted(halted)
  );

  always #5 clock = ~clock;

  // Instruction memory: output follows the address on the falling edge.
  always @(negedge clock) instrucao <= mem[endereco];

  task automatic do_reset();
    reset_n = 1'b0; run = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_addr = 8'd0;
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    tests++;
    if ({endereco, instr_out, instr_pc, instr_valid, busy, halted} !== {8'd10, 8'd0, 8'd0, 3'b000}) begin
      fails++;
      $display("FAIL reset_values: endereco=%0d out=%h pc=%0d v/b/h=%b%b%b want 10/00/0/000",
               endereco, instr_out, instr_pc, instr_valid, busy, halted);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    tests++;
    if ({busy, instr_valid, endereco} !== {2'b00, 8'd10}) begin
      fails++;
      $display("FAIL idle_hold: busy=%b valid=%b endereco=%0d want 0/0/10", busy, instr_valid, endereco);
    end
  endtask

  task automatic test_straight();
    do_reset();
    run = 1'b1; instr_ready = 1'b1;
    sb.push_back(xfer_t'{8'd10, 8'h08});
    sb.push_back(xfer_t'{8'd11, 8'h10});
    sb.push_back(xfer_t'{8'd12, 8'h17});
    @(negedge clock);
    tests++;
    if ({busy, instr_valid} !== 2'b10) begin
      fails++;
      $display("FAIL straight_enter: busy=%b valid=%b want 1/0", busy, instr_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      tests++;
      if (!instr_valid) begin
        fails++;
        $display("FAIL straight_valid[%0d]: instr_valid=0 want 1", i);
      end else begin
        e = sb.pop_front();
        if ({instr_pc, instr_out} !== {e.pc, e.word}) begin
          fails++;
          $display("FAIL straight_xfer[%0d]: pc/word=%0d/%h want %0d/%h", i, instr_pc, instr_out, e.pc, e.word);
        end
      end
    end
    tests++;
    if (endereco !== 8'd13) begin
      fails++;
      $display("FAIL straight_addr: endereco=%0d want 13", endereco);
    end
  endtask

  task automatic test_stall();
    do_reset();
    run = 1'b1; instr_ready = 1'b1;
    sb.push_back(xfer_t'{8'd10, 8'h08});
    sb.push_back(xfer_t'{8'd11, 8'h10});
    sb.push_back(xfer_t'{8'd12, 8'h17});
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (i == 1) begin
        instr_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tests++;
          if ({instr_valid, instr_out, instr_pc, endereco} !== {1'b1, 8'h10, 8'd11, 8'd12}) begin
            fails++;
            $display("FAIL stall_hold[%0d]: v=%b out=%h pc=%0d endereco=%0d want 1/10/11/12",
                     s, instr_valid, instr_out, instr_pc, endereco);
          end
          @(negedge clock);
        end
        instr_ready = 1'b1;
      end
      tests++;
      if (!instr_valid) begin
        fails++;
        $display("FAIL stall_valid[%0d]: instr_valid=0 want 1", i);
      end else begin
        e = sb.pop_front();
        if ({instr_pc, instr_out} !== {e.pc, e.word}) begin
          fails++;
          $display("FAIL stall_xfer[%0d]: pc/word=%0d/%h want %0d/%h", i, instr_pc, instr_out, e.pc, e.word);
        end
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    run = 1'b1; instr_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    instr_ready = 1'b0;
    @(negedge clock);
    tests++;
    if ({instr_valid, instr_pc} !== {1'b1, 8'd10}) begin
      fails++;
      $display("FAIL redirect_pre: valid=%b pc=%0d want 1/10", instr_valid, instr_pc);
    end
    redirect_valid = 1'b1; redirect_addr = 8'd40;
    @(negedge clock);
    redirect_valid = 1'b0; instr_ready = 1'b1;
    tests++;
    if ({instr_valid, endereco} !== {1'b0, 8'd40}) begin
      fails++;
      $display("FAIL redirect_flush: valid=%b endereco=%0d want 0/40", instr_valid, endereco);
    end
    sb.push_back(xfer_t'{8'd40, 8'd40 ^ 8'h5A});
    sb.push_back(xfer_t'{8'd41, 8'd41 ^ 8'h5A});
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      tests++;
      if (!instr_valid) begin
        fails++;
        $display("FAIL redirect_valid[%0d]: instr_valid=0 want 1", i);
      end else begin
        e = sb.pop_front();
        if ({instr_pc, instr_out} !== {e.pc, e.word}) begin
          fails++;
          $display("FAIL redirect_xfer[%0d]: pc/word=%0d/%h want %0d/%h", i, instr_pc, instr_out, e.pc, e.word);
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_valid = 1'b1; redirect_addr = 8'd254;
    @(negedge clock);
    redirect_valid = 1'b0;
    tests++;
    if ({busy, endereco} !== {1'b0, 8'd254}) begin
      fails++;
      $display("FAIL wrap_idle_redirect: busy=%b endereco=%0d want 0/254", busy, endereco);
    end
    run = 1'b1; instr_ready = 1'b1;
    sb.push_back(xfer_t'{8'd254, 8'hA4});
    sb.push_back(xfer_t'{8'd255, 8'hA5});
    sb.push_back(xfer_t'{8'd0,   8'h5A});
    sb.push_back(xfer_t'{8'd1,   8'h5B});
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      tests++;
      if (!instr_valid) begin
        fails++;
        $display("FAIL wrap_valid[%0d]: instr_valid=0 want 1", i);
      end else begin
        e = sb.pop_front();
        if ({instr_pc, instr_out} !== {e.pc, e.word}) begin
          fails++;
          $display("FAIL wrap_xfer[%0d]: pc/word=%0d/%h want %0d/%h", i, instr_pc, instr_out, e.pc, e.word);
        end
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    redirect_valid = 1'b1; redirect_addr = 8'd60;
    @(negedge clock);
    redirect_valid = 1'b0;
    run = 1'b1; instr_ready = 1'b1;
    for (int a = 60; a < 65; a++) sb.push_back(xfer_t'{8'(a), 8'(a) ^ 8'h5A});
    sb.push_back(xfer_t'{8'd65, 8'hE0});
    @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      tests++;
      if (!instr_valid) begin
        fails++;
        $display("FAIL halt_run_valid[%0d]: instr_valid=0 want 1", i);
      end else begin
        e = sb.pop_front();
        if ({instr_pc, instr_out} !== {e.pc, e.word}) begin
          fails++;
          $display("FAIL halt_run_xfer[%0d]: pc/word=%0d/%h want %0d/%h", i, instr_pc, instr_out, e.pc, e.word);
        end
      end
    end
`ifdef FETCH_HALT_DETECT_EN
    tests++;
    if ({halted, busy, endereco} !== {2'b10, 8'd65}) begin
      fails++;
      $display("FAIL halt_enter: halted=%b busy=%b endereco=%0d want 1/0/65", halted, busy, endereco);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      tests++;
      if ({instr_valid, halted, endereco} !== {2'b01, 8'd65}) begin
        fails++;
        $display("FAIL halt_stay[%0d]: valid=%b halted=%b endereco=%0d want 0/1/65",
                 i, instr_valid, halted, endereco);
      end
    end
    redirect_valid = 1'b1; redirect_addr = 8'd10;
    @(negedge clock);
    redirect_valid = 1'b0;
    tests++;
    if ({halted, busy} !== 2'b01) begin
      fails++;
      $display("FAIL halt_exit: halted=%b busy=%b want 0/1", halted, busy);
    end
    sb.push_back(xfer_t'{8'd10, 8'h08});
    @(negedge clock);
    tests++;
    if (!instr_valid) begin
      fails++;
      $display("FAIL halt_resume_valid: instr_valid=0 want 1");
    end else begin
      e = sb.pop_front();
      if ({instr_pc, instr_out} !== {e.pc, e.word}) begin
        fails++;
        $display("FAIL halt_resume_xfer: pc/word=%0d/%h want %0d/%h", instr_pc, instr_out, e.pc, e.word);
      end
    end
`else
    @(negedge clock);
    tests++;
    if ({instr_valid, instr_pc, halted} !== {1'b1, 8'd66, 1'b0}) begin
      fails++;
      $display("FAIL nohalt_continue: valid=%b pc=%0d halted=%b want 1/66/0", instr_valid, instr_pc, halted);
    end
`endif
    run = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    run = 1'b1; instr_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    tests++;
    if ({instr_valid, endereco} !== {1'b1, 8'd11}) begin
      fails++;
      $display("FAIL reset_mid_pre: valid=%b endereco=%0d want 1/11", instr_valid, endereco);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({endereco, instr_out, instr_pc, instr_valid, busy, halted} !== {8'd10, 8'd0, 8'd0, 3'b000}) begin
      fails++;
      $display("FAIL reset_mid: endereco=%0d out=%h pc=%0d v/b/h=%b%b%b want 10/00/0/000",
               endereco, instr_out, instr_pc, instr_valid, busy, halted);
    end
    @(negedge clock);
    reset_n = 1'b1; run = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[10] = 8'h08;
    mem[11] = 8'h10;
    mem[12] = 8'h17;
    mem[65] = 8'hE0;
    test_reset();
    test_straight();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
